// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract datapath.
package pipe_addsub_pkg;

   // Upper bound on WIDTH for the constant helper functions below
   localparam int unsigned MAX_W = 1024;

   // Width of one pipeline slice
   function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   // Legal geometry: nonzero stage count that divides the width evenly
   function automatic bit geometry_ok(input int unsigned width, input int unsigned stages);
      return (stages != 0) && (width != 0) && (width <= MAX_W) && ((width % stages) == 0);
   endfunction

   // Most positive signed value, 0111..1
   function automatic logic [MAX_W-1:0] sat_pos(input int unsigned width);
      return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
   endfunction

   // Most negative signed value, 1000..0
   function automatic logic [MAX_W-1:0] sat_neg(input int unsigned width);
      return MAX_W'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
interface pipe_addsub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             cout;
   logic             ovf;

   // Operand source and result consumer side
   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, S, cout, ovf
   );

   // Datapath side
   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, S, cout, ovf
   );
endinterface

// File: rtl/pipe_addsub_slice.sv
// Combinational W-bit ripple full-adder chain used by each pipeline slice.
module addsub_slice #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb_in
);
   logic [W:0] c;

   // Ripple the carry bit by bit through full adders
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < int'(W); i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co       = c[W];
   assign c_msb_in = c[W-1];
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: WIDTH-bit ripple add split into STAGES registered slices.
// Optional PIPE_ADDSUB_SAT_EN: saturate S to the signed limit on overflow.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   pipe_addsub_if.slave bus
);
   localparam int unsigned SW   = slice_w(WIDTH, STAGES);
   localparam int unsigned LAST = STAGES - 1;

   if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
      $error("pipe_addsub: WIDTH must be a nonzero multiple of STAGES");
   end

`ifdef PIPE_ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

   // Per-stage token: acc holds finished sum slices below and untouched a-slices above
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] cy;
   logic              ovf_r;
   logic [WIDTH-1:0]  acc     [STAGES];
   logic [WIDTH-1:0]  opb     [STAGES];
   logic [WIDTH-1:0]  in_acc  [STAGES];
   logic [WIDTH-1:0]  in_b    [STAGES];
   logic [WIDTH-1:0]  nxt_acc [STAGES];
   logic [SW-1:0]     sl_s    [STAGES];
   logic              sl_cm   [STAGES];
   logic [STAGES-1:0] in_c;
   logic [STAGES-1:0] in_v;
   logic [STAGES-1:0] sl_co;
   logic [STAGES:0]   ld;

   // Stage inputs: port operands for stage 0, previous stage token otherwise
   always_comb begin
      in_acc[0] = bus.a;
      in_b[0]   = bus.sub ? ~bus.b : bus.b;
      in_c[0]   = bus.ci;
      in_v[0]   = bus.in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
         in_acc[k] = acc[k-1];
         in_b[k]   = opb[k-1];
         in_c[k]   = cy[k-1];
         in_v[k]   = vld[k-1];
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
      addsub_slice #(.W(SW)) u_slice (
         .x        (in_acc[k][k*SW +: SW]),
         .y        (in_b[k][k*SW +: SW]),
         .cin      (in_c[k]),
         .s        (sl_s[k]),
         .co       (sl_co[k]),
         .c_msb_in (sl_cm[k])
      );
   end

   // Splice each new sum slice into the token; saturate in the last stage
   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         nxt_acc[k]             = in_acc[k];
         nxt_acc[k][k*SW +: SW] = sl_s[k];
      end
`ifdef PIPE_ADDSUB_SAT_EN
      // On overflow a' and b' share a sign, so a's MSB gives the true sign
      if (sl_cm[LAST] ^ sl_co[LAST]) begin
         nxt_acc[LAST] = in_acc[LAST][WIDTH-1] ? SAT_NEG : SAT_POS;
      end
`endif
   end

   // Load chain: a stage loads when empty or when its successor loads
   always_comb begin
      ld         = '0;
      ld[STAGES] = bus.out_ready;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         ld[k] = ~vld[k] | ld[k+1];
      end
   end

   // Stage registers; data only moves with a real token so S holds on bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         vld   <= '0;
         cy    <= '0;
         ovf_r <= 1'b0;
         for (int k = 0; k < int'(STAGES); k++) begin
            acc[k] <= '0;
            opb[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (ld[k]) begin
               vld[k] <= in_v[k];
            end
            if (ld[k] && in_v[k]) begin
               acc[k] <= nxt_acc[k];
               opb[k] <= in_b[k];
               cy[k]  <= sl_co[k];
            end
         end
         if (ld[LAST] && in_v[LAST]) begin
            ovf_r <= sl_cm[LAST] ^ sl_co[LAST];
         end
      end
   end

   assign bus.in_ready  = ld[0];
   assign bus.out_valid = vld[LAST];
   assign bus.S         = acc[LAST];
   assign bus.cout      = cy[LAST];
   assign bus.ovf       = ovf_r;
endmodule
